// File: rtl/sy_ppl_pc_gen.sv
// Frontend F0/F1: fetch-address generation with zero-bubble BTB redirect.
// Backend redirects take priority over BTB hits, and BTB hits take priority over the sequential PC.
module sy_ppl_pc_gen #(
    parameter int unsigned AWTH        = 64,
    parameter logic [63:0] RESET_VEC   = 64'h0000_0000_8000_0000,
    parameter int unsigned FETCH_BYTES = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            fetch_en_i,
    input  logic            redirect_vld_i,
    input  logic [AWTH-1:0] redirect_pc_i,
    output logic            fetch_req_vld_o,
    input  logic            fetch_req_rdy_i,
    output logic [AWTH-1:0] fetch_addr_o,
    output logic [AWTH-1:0] btb_vaddr_o,
    input  logic            btb_pred_vld_i,
    input  logic [AWTH-1:0] btb_pred_target_i,
    output logic            pred_vld_o,
    output logic [AWTH-1:0] pred_pc_o,
    output logic            pred_taken_o,
    output logic [AWTH-1:0] pred_target_o
);

    localparam logic [AWTH-1:0] L_RST_VEC  = RESET_VEC[AWTH-1:0];
    localparam logic [AWTH-1:0] L_FB       = AWTH'(FETCH_BYTES);
    localparam logic [AWTH-1:0] L_BLK_MASK = ~(L_FB - AWTH'(1));

    logic [AWTH-1:0] r_pc;
    logic            r_f1_vld;
    logic [AWTH-1:0] r_f1_pc;

    logic            w_f1_hit;
    logic            w_taken;
    logic            w_accept;
    logic [AWTH-1:0] w_eff_raw;
    logic [AWTH-1:0] w_eff;
    logic [AWTH-1:0] w_next_seq;

    // Every output is gated by rst_i, so reset is visible in the same cycle it is asserted.
    assign w_f1_hit  = rst_i & r_f1_vld & btb_pred_vld_i;
    assign w_taken   = w_f1_hit & ~redirect_vld_i;

    assign w_eff_raw = !rst_i         ? L_RST_VEC         :
                       redirect_vld_i ? redirect_pc_i     :
                       w_f1_hit       ? btb_pred_target_i :
                                        r_pc;
    assign w_eff      = w_eff_raw & ~AWTH'(1);
    assign w_next_seq = (w_eff & L_BLK_MASK) + L_FB;

    assign fetch_req_vld_o = rst_i & fetch_en_i;
    assign w_accept        = fetch_req_vld_o & fetch_req_rdy_i;

    assign fetch_addr_o  = w_eff;
    assign btb_vaddr_o   = w_eff;
    assign pred_vld_o    = rst_i & r_f1_vld & ~redirect_vld_i;
    assign pred_pc_o     = rst_i ? r_f1_pc : L_RST_VEC;
    assign pred_taken_o  = w_taken;
    assign pred_target_o = w_taken ? btb_pred_target_i : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_pc     <= L_RST_VEC;
            r_f1_vld <= 1'b0;
            r_f1_pc  <= L_RST_VEC;
        end else if (w_accept) begin
            r_pc     <= w_next_seq;
            r_f1_vld <= 1'b1;
            r_f1_pc  <= w_eff;
        end else begin
            // Holding eff keeps a consumed hit or redirect alive across stalls.
            r_pc     <= w_eff;
            r_f1_vld <= 1'b0;
        end
    end

endmodule

// File: doc/sy_ppl_pc_gen.md
Name: sy_ppl_pc_gen

Overview:
Fetch-address generator (F0) and BTB-consume stage (F1) of the frontend.
- Drives the fetch address to the I-cache request port and the BTB read address (`vaddr`).
- One cycle later, consumes the BTB prediction for the address accepted in the previous cycle and redirects fetch with zero bubbles.
- Backend redirects (mispredict, exception, fence) have top priority.

Parameters:
- AWTH, 64 (from sy_pkg): virtual address width.
- RESET_VEC, 64'h0000_0000_8000_0000: first fetch address after reset.
- FETCH_BYTES, 4: fetch block size in bytes; must be a power of two, 2 or greater.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-low (one clock; reset is synchronous and active-low).
- fetch_en_i  in  1  frontend run enable; 0 halts new requests.
- redirect_vld_i  in  1  backend redirect request.
- redirect_pc_i  in  AWTH  backend redirect target.
- fetch_req_vld_o  out  1  I-cache request valid.
- fetch_req_rdy_i  in  1  I-cache request ready.
- fetch_addr_o  out  AWTH  I-cache request address, halfword aligned.
- btb_vaddr_o  out  AWTH  BTB read address; always equal to fetch_addr_o.
- btb_pred_vld_i  in  1  BTB hit, for the btb_vaddr_o of the previous cycle.
- btb_pred_target_i  in  AWTH  BTB target, same timing as btb_pred_vld_i.
- pred_vld_o  out  1  prediction-metadata valid for the block accepted last cycle.
- pred_pc_o  out  AWTH  fetch address of that block.
- pred_taken_o  out  1  BTB predicted taken for that block.
- pred_target_o  out  AWTH  predicted target; 0 when not taken.

Behaviour:
- State:
  - pc_q: next sequential fetch address.
  - f1_vld_q and f1_pc_q: the address accepted last cycle.
- Reset (rst_i=0 at a clock edge):
  - pc_q=RESET_VEC, f1_vld_q=0.
  - While rst_i=0: fetch_req_vld_o=0, pred_vld_o=0, pred_taken_o=0, pred_target_o=0.
  - fetch_addr_o, btb_vaddr_o and pred_pc_o show RESET_VEC.
- Reset applied mid-operation discards any F1 prediction. The first request after reset release is RESET_VEC.
- f1_hit = f1_vld_q & btb_pred_vld_i.
- Effective address eff, combinational, priority order:
  1. redirect_vld_i: redirect_pc_i.
  2. f1_hit: btb_pred_target_i.
  3. otherwise: pc_q.
- eff[0] is forced to 0.
- fetch_addr_o = btb_vaddr_o = eff.
- fetch_req_vld_o = rst_i & fetch_en_i. It has no dependency on fetch_req_rdy_i.
- Accept = fetch_req_vld_o & fetch_req_rdy_i.
- On accept:
  - pc_q <= (eff & ~(FETCH_BYTES-1)) + FETCH_BYTES, modulo 2^AWTH (wraps to 0).
  - f1_vld_q <= 1, f1_pc_q <= eff.
- No accept: pc_q <= eff and f1_vld_q <= 0. A consumed hit or redirect is therefore held and never lost.
- The BTB prediction is used only when f1_vld_q=1. A stalled or halted cycle presents the same address, so the BTB re-read stays consistent.
- Metadata:
  - pred_vld_o = f1_vld_q & ~redirect_vld_i.
  - pred_pc_o = f1_pc_q.
  - pred_taken_o = f1_hit & ~redirect_vld_i.
  - pred_target_o = btb_pred_target_i when pred_taken_o, else 0.
  - Valid for exactly one cycle per accepted block.
- Redirect in the same cycle as f1_hit: redirect wins, and the metadata of the squashed F1 block is suppressed.
- Redirect while the I-cache is not ready: pc_q <= redirect_pc_i; that address is presented on the following cycles until accepted.
- fetch_en_i=0:
  - No new requests; f1_vld_q clears at the next edge.
  - A pending F1 hit is still folded into pc_q (hit applied, address held).
- Latency:
  - Redirect to fetch_addr_o: 0 cycles (combinational).
  - BTB hit to fetch_addr_o: 0 cycles after the F1 cycle, which is 1 cycle after acceptance.
- Combinational paths: btb_pred_* and redirect_* reach fetch_addr_o and btb_vaddr_o.
- No combinational path from fetch_req_rdy_i to any output.

Test Plan:
1. Reset release, rdy=1, no BTB hits -> fetch_addr_o sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; pred_vld_o=1 from the 2nd cycle with pred_pc_o lagging by one.
2. Hit after 0x8000_0008 is accepted: btb_pred_vld_i=1, target 0x8000_1002 -> in the same cycle fetch_addr_o=0x8000_1002, pred_taken_o=1, pred_pc_o=0x8000_0008, pred_target_o=0x8000_1002; next address 0x8000_1004.
3. Same hit with rdy=0 for 3 cycles -> fetch_addr_o holds 0x8000_1002 for all 3 cycles; pred_vld_o=1 only in the hit cycle; after rdy=1 the next address is 0x8000_1004.
4. redirect_vld_i=1, pc 0x8000_2000, in the same cycle as a BTB hit to 0x8000_1002 -> fetch_addr_o=0x8000_2000, pred_vld_o=0, pred_taken_o=0; next address 0x8000_2004.
5. Wrap-around: redirect to 0xFFFF_FFFF_FFFF_FFFE, accepted -> next fetch_addr_o=0x0; then 0x4.
6. rst_i=0 for one edge while a hit is pending in F1 -> fetch_req_vld_o=0 during reset, pred_vld_o=0; first post-reset address 0x8000_0000, not the BTB target.
